// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute register with EX/MEM/WB operand bypass and load-use bubble; bypass network enabled by DECODE_BYPASS_EN.
// Latency: 1 cycle. Backpressure: stall holds, flush/hazard_stall/!valid_D load a bubble; hazard_stall asks decode to hold.
module id_ex_operand_stage #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         valid_D,
  input  logic [N-1:0] A1_D,
  input  logic [N-1:0] A2_D,
  input  logic [N-1:0] A3_D,
  input  logic [M-1:0] RD1_D,
  input  logic [M-1:0] RD2_D,
  input  logic [M-1:0] imm_D,
  input  logic         reg_write_D,
  input  logic         mem_write_D,
  input  logic         mem_to_reg_D,
  input  logic         alu_src_D,
  input  logic [3:0]   alu_ctrl_D,
  input  logic [3:0]   cond_D,
  input  logic [M-1:0] ex_result,
  input  logic         mem_reg_write,
  input  logic [N-1:0] mem_A3,
  input  logic [M-1:0] mem_result,
  input  logic         wb_reg_write,
  input  logic [N-1:0] wb_A3,
  input  logic [M-1:0] wb_result,
  output logic         valid_E,
  output logic [M-1:0] SrcA_E,
  output logic [M-1:0] WriteData_E,
  output logic [M-1:0] imm_E,
  output logic [N-1:0] A3_E,
  output logic         reg_write_E,
  output logic         mem_write_E,
  output logic         mem_to_reg_E,
  output logic         alu_src_E,
  output logic [3:0]   alu_ctrl_E,
  output logic [3:0]   cond_E,
  output logic [1:0]   fwd_sel_A,
  output logic [1:0]   fwd_sel_B,
  output logic         hazard_stall
);

  localparam logic [N-1:0] PC_REG = '1;

  typedef struct packed {
    logic         valid;
    logic [M-1:0] srca;
    logic [M-1:0] wdata;
    logic [M-1:0] imm;
    logic [N-1:0] a3;
    logic         reg_write;
    logic         mem_write;
    logic         mem_to_reg;
    logic         alu_src;
    logic [3:0]   alu_ctrl;
    logic [3:0]   cond;
    logic [1:0]   fsel_a;
    logic [1:0]   fsel_b;
  } ex_t;

  ex_t q, d;
  logic [1:0] sel_a, sel_b;
  logic [M-1:0] op_a, op_b;
  logic load_use;

  // Only a load in E stalls when the bypass exists; its data arrives via MEM next cycle.
  assign load_use = valid_D & q.valid & q.mem_to_reg & q.reg_write &
                    (((A1_D == q.a3) & (A1_D != PC_REG)) |
                     ((A2_D == q.a3) & (A2_D != PC_REG)));

`ifdef DECODE_BYPASS_EN
  function automatic logic [1:0] fwd_src(input logic [N-1:0] src);
    if (src == PC_REG)
      return 2'd0;
    if (q.valid && q.reg_write && !q.mem_to_reg && q.a3 == src)
      return 2'd1;
    if (mem_reg_write && mem_A3 == src)
      return 2'd2;
    if (wb_reg_write && wb_A3 == src)
      return 2'd3;
    return 2'd0;
  endfunction

  assign sel_a        = fwd_src(A1_D);
  assign sel_b        = fwd_src(A2_D);
  assign hazard_stall = ~reset & load_use;
`else
  function automatic logic raw(input logic [N-1:0] src);
    return (src != PC_REG) &
           ((q.valid & q.reg_write & (q.a3 == src)) |
            (mem_reg_write & (mem_A3 == src)) |
            (wb_reg_write & (wb_A3 == src)));
  endfunction

  // Without bypass, any in-flight writer of a source keeps inserting bubbles until it retires.
  assign sel_a        = 2'd0;
  assign sel_b        = 2'd0;
  assign hazard_stall = ~reset & (load_use | (valid_D & (raw(A1_D) | raw(A2_D))));
`endif

  always_comb begin
    op_a = RD1_D;
    case (sel_a)
      2'd1:    op_a = ex_result;
      2'd2:    op_a = mem_result;
      2'd3:    op_a = wb_result;
      default: op_a = RD1_D;
    endcase
    op_b = RD2_D;
    case (sel_b)
      2'd1:    op_b = ex_result;
      2'd2:    op_b = mem_result;
      2'd3:    op_b = wb_result;
      default: op_b = RD2_D;
    endcase
  end

  always_comb begin
    d = '0;
    if (valid_D && !hazard_stall) begin
      d.valid      = 1'b1;
      d.srca       = op_a;
      d.wdata      = op_b;
      d.imm        = imm_D;
      d.a3         = A3_D;
      d.reg_write  = reg_write_D;
      d.mem_write  = mem_write_D;
      d.mem_to_reg = mem_to_reg_D;
      d.alu_src    = alu_src_D;
      d.alu_ctrl   = alu_ctrl_D;
      d.cond       = cond_D;
      d.fsel_a     = sel_a;
      d.fsel_b     = sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!stall)
      q <= d;
  end

  assign valid_E      = q.valid;
  assign SrcA_E       = q.srca;
  assign WriteData_E  = q.wdata;
  assign imm_E        = q.imm;
  assign A3_E         = q.a3;
  assign reg_write_E  = q.reg_write;
  assign mem_write_E  = q.mem_write;
  assign mem_to_reg_E = q.mem_to_reg;
  assign alu_src_E    = q.alu_src;
  assign alu_ctrl_E   = q.alu_ctrl;
  assign cond_E       = q.cond;
  assign fwd_sel_A    = q.fsel_a;
  assign fwd_sel_B    = q.fsel_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow DECODE_BYPASS_EN when defined.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_D;
  logic [3:0]  A1_D, A2_D, A3_D;
  logic [31:0] RD1_D, RD2_D, imm_D;
  logic        reg_write_D, mem_write_D, mem_to_reg_D, alu_src_D;
  logic [3:0]  alu_ctrl_D, cond_D;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        mem_reg_write, wb_reg_write;
  logic [3:0]  mem_A3, wb_A3;
  logic        valid_E;
  logic [31:0] SrcA_E, WriteData_E, imm_E;
  logic [3:0]  A3_E;
  logic        reg_write_E, mem_write_E, mem_to_reg_E, alu_src_E;
  logic [3:0]  alu_ctrl_E, cond_E;
  logic [1:0]  fwd_sel_A, fwd_sel_B;
  logic        hazard_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.N(4), .M(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_D(valid_D),
    .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .imm_D(imm_D),
    .reg_write_D(reg_write_D), .mem_write_D(mem_write_D), .mem_to_reg_D(mem_to_reg_D),
    .alu_src_D(alu_src_D), .alu_ctrl_D(alu_ctrl_D), .cond_D(cond_D),
    .ex_result(ex_result), .mem_reg_write(mem_reg_write), .mem_A3(mem_A3),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_A3(wb_A3), .wb_result(wb_result),
    .valid_E(valid_E), .SrcA_E(SrcA_E), .WriteData_E(WriteData_E), .imm_E(imm_E), .A3_E(A3_E),
    .reg_write_E(reg_write_E), .mem_write_E(mem_write_E), .mem_to_reg_E(mem_to_reg_E),
    .alu_src_E(alu_src_E), .alu_ctrl_E(alu_ctrl_E), .cond_E(cond_E),
    .fwd_sel_A(fwd_sel_A), .fwd_sel_B(fwd_sel_B), .hazard_stall(hazard_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; valid_D = 0;
    A1_D = 0; A2_D = 0; A3_D = 0; RD1_D = 0; RD2_D = 0; imm_D = 0;
    reg_write_D = 0; mem_write_D = 0; mem_to_reg_D = 0; alu_src_D = 0;
    alu_ctrl_D = 0; cond_D = 0;
    ex_result = 0; mem_reg_write = 0; mem_A3 = 0; mem_result = 0;
    wb_reg_write = 0; wb_A3 = 0; wb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_in();
    reset = 1;
    valid_D = 1; reg_write_D = 1; RD1_D = 32'h55; A3_D = 4;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", valid_E, 0);
      check("rst_rw", reg_write_E, 0);
      check("rst_srca", SrcA_E, 0);
      check("rst_a3", A3_E, 0);
      check("rst_haz", hazard_stall, 0);
    end

    // First load after reset release
    reset = 0;
    clr_in();
    valid_D = 1; A1_D = 5; RD1_D = 32'h11; imm_D = 32'h123; cond_D = 4'hE; alu_src_D = 1;
    tick();
    check("first_srca", SrcA_E, 32'h11);
    check("first_valid", valid_E, 1);
    check("first_imm", imm_E, 32'h123);
    check("first_cond", cond_E, 4'hE);
    check("first_fsa", fwd_sel_A, 0);

    // ADD R1 into E, then consumer of R1 with MEM also writing R1
    clr_in();
    valid_D = 1; A1_D = 5; A2_D = 6; A3_D = 1; reg_write_D = 1; alu_ctrl_D = 4;
    tick();
    check("add_a3", A3_E, 1);
    check("add_rw", reg_write_E, 1);
    check("add_alu", alu_ctrl_E, 4);
    clr_in();
    valid_D = 1; A1_D = 1; A2_D = 7; A3_D = 8; RD1_D = 32'h3;
    ex_result = 32'h5; mem_reg_write = 1; mem_A3 = 1; mem_result = 32'h7;
    #1;
`ifdef DECODE_BYPASS_EN
    check("ex_fwd_haz", hazard_stall, 0);
    tick();
    check("ex_fwd_srca", SrcA_E, 32'h5);
    check("ex_fwd_sel", fwd_sel_A, 1);
`else
    check("ex_raw_haz", hazard_stall, 1);
    tick();
    check("ex_raw_bubble", valid_E, 0);
    mem_reg_write = 0; RD1_D = 32'h5;
    #1;
    check("ex_raw_clear", hazard_stall, 0);
    tick();
    check("ex_raw_srca", SrcA_E, 32'h5);
    check("ex_raw_sel", fwd_sel_A, 0);
`endif

    // WB-only writer of R2 with stale register file data
    clr_in();
    valid_D = 1; A1_D = 9; A2_D = 2; RD2_D = 0;
    wb_reg_write = 1; wb_A3 = 2; wb_result = 32'hAB;
    #1;
`ifdef DECODE_BYPASS_EN
    check("wb_fwd_haz", hazard_stall, 0);
    tick();
    check("wb_fwd_wd", WriteData_E, 32'hAB);
    check("wb_fwd_sel", fwd_sel_B, 3);
`else
    check("wb_raw_haz", hazard_stall, 1);
    tick();
    check("wb_raw_bubble", valid_E, 0);
    wb_reg_write = 0; RD2_D = 32'hAB;
    tick();
    check("wb_raw_wd", WriteData_E, 32'hAB);
    check("wb_raw_sel", fwd_sel_B, 0);
`endif

    // LDR R3 then load-use on R3
    clr_in();
    valid_D = 1; A1_D = 9; A2_D = 10; A3_D = 3; reg_write_D = 1; mem_to_reg_D = 1;
    tick();
    check("ldr_mtr", mem_to_reg_E, 1);
    check("ldr_valid", valid_E, 1);
    clr_in();
    valid_D = 1; A1_D = 3; A2_D = 11; A3_D = 12;
    #1;
    check("lu_haz", hazard_stall, 1);
    tick();
    check("lu_bubble_v", valid_E, 0);
    check("lu_bubble_rw", reg_write_E, 0);
    mem_reg_write = 1; mem_A3 = 3; mem_result = 32'h99;
    #1;
`ifdef DECODE_BYPASS_EN
    check("lu_mem_haz", hazard_stall, 0);
    tick();
    check("lu_mem_srca", SrcA_E, 32'h99);
    check("lu_mem_sel", fwd_sel_A, 2);
`else
    check("lu_mem_haz", hazard_stall, 1);
    tick();
    check("lu_mem_bubble", valid_E, 0);
    mem_reg_write = 0; RD1_D = 32'h99;
    tick();
    check("lu_rf_srca", SrcA_E, 32'h99);
    check("lu_rf_sel", fwd_sel_A, 0);
`endif

    // R15 is never bypassed even when every source targets it
    clr_in();
    valid_D = 1; A1_D = 9; A2_D = 10; A3_D = 15; reg_write_D = 1;
    tick();
    clr_in();
    valid_D = 1; A1_D = 15; A2_D = 15; A3_D = 13; reg_write_D = 1;
    RD1_D = 32'h108; RD2_D = 32'h10C; ex_result = 32'hE;
    mem_reg_write = 1; mem_A3 = 15; mem_result = 32'hF;
    wb_reg_write = 1; wb_A3 = 15; wb_result = 32'h1F;
    #1;
    check("r15_haz", hazard_stall, 0);
    tick();
    check("r15_srca", SrcA_E, 32'h108);
    check("r15_sela", fwd_sel_A, 0);
    check("r15_wd", WriteData_E, 32'h10C);
    check("r15_selb", fwd_sel_B, 0);

    // Stall freezes, then flush wins over stall
    mem_reg_write = 0; wb_reg_write = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin
      RD1_D = 32'hD00 + i; A3_D = 4'(i); A1_D = 4'(i + 4);
      tick();
      check("stall_srca", SrcA_E, 32'h108);
      check("stall_a3", A3_E, 13);
      check("stall_valid", valid_E, 1);
    end
    flush = 1;
    tick();
    check("flush_valid", valid_E, 0);
    check("flush_rw", reg_write_E, 0);
    check("flush_srca", SrcA_E, 0);

    // valid_D low yields a bubble with no write enables
    clr_in();
    reg_write_D = 1; mem_write_D = 1; RD1_D = 32'h77;
    tick();
    check("vd0_valid", valid_E, 0);
    check("vd0_rw", reg_write_E, 0);
    check("vd0_mw", mem_write_E, 0);
    check("vd0_srca", SrcA_E, 0);
    valid_D = 1;
    tick();
    check("vd1_mw", mem_write_E, 1);
    check("vd1_srca", SrcA_E, 32'h77);

    // Reset during stall with a pending load-use
    clr_in();
    valid_D = 1; A1_D = 9; A2_D = 10; A3_D = 3; reg_write_D = 1; mem_to_reg_D = 1;
    tick();
    clr_in();
    valid_D = 1; A1_D = 3; stall = 1; reset = 1;
    #1;
    check("rst_stall_haz", hazard_stall, 0);
    tick();
    check("rst_stall_valid", valid_E, 0);
    check("rst_stall_mtr", mem_to_reg_E, 0);
    check("rst_stall_a3", A3_E, 0);
    reset = 0; stall = 0;
    #1;
    check("post_rst_haz", hazard_stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the 16-entry register file.
- Captures the RD1/RD2 read data together with the decoded control for one instruction and presents them to the execute stage.
- Before capture, bypasses newer results from EX, MEM and WB so that execute always receives current operands.
- Detects load-use hazards, requests an upstream stall and inserts a bubble; also honours external stall and flush.

Parameters:
N, 4, register address width (register 15 = all-ones address, the PC+8 value)
M, 32, data width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stage registers
flush  in  1  replace stage contents with a bubble
valid_D  in  1  decode-stage instruction valid
A1_D, A2_D, A3_D  in  N  source and destination register addresses
RD1_D, RD2_D  in  M  register file read data
imm_D  in  M  extended immediate
reg_write_D, mem_write_D, mem_to_reg_D, alu_src_D  in  1 each  decoded control
alu_ctrl_D  in  4  ALU operation
cond_D  in  4  condition field
ex_result  in  M  ALU result of the instruction currently held by this stage
mem_reg_write  in  1  MEM-stage write enable
mem_A3  in  N  MEM-stage destination
mem_result  in  M  MEM-stage result
wb_reg_write  in  1  WB write enable (same value as the register file WE3)
wb_A3  in  N  WB destination
wb_result  in  M  WB result
valid_E  out  1  execute-stage instruction valid
SrcA_E, WriteData_E, imm_E  out  M  registered operands
A3_E  out  N  registered destination
reg_write_E, mem_write_E, mem_to_reg_E, alu_src_E  out  1 each  registered control
alu_ctrl_E, cond_E  out  4  registered control
fwd_sel_A, fwd_sel_B  out  2  registered bypass source: 0 = register file, 1 = EX, 2 = MEM, 3 = WB
hazard_stall  out  1  combinational load-use stall request to fetch/decode

Behaviour:
- Reset (synchronous, active-high): every registered output clears to 0; valid_E = 0.
- Latency: 1 cycle from decode inputs to _E outputs.
- Per-edge priority: reset > flush > stall > hazard_stall > normal load.
  - flush: load a bubble; all outputs 0, including valid_E and every write enable.
  - stall (without flush): hold all registers unchanged.
  - hazard_stall (no flush, no stall): load a bubble; upstream holds decode.
  - Otherwise: load the decode inputs.
- Bubble invariant: reg_write_E and mem_write_E are never 1 while valid_E = 0.
- Operand selection at capture, per operand X in {A1_D, A2_D}:
  - If X = 15: always use the RDx_D value; never bypassed.
  - EX bypass: hit when valid_E, reg_write_E, !mem_to_reg_E and A3_E == X; selects ex_result.
  - MEM bypass: hit when mem_reg_write and mem_A3 == X; selects mem_result.
  - WB bypass: hit when wb_reg_write and wb_A3 == X; selects wb_result. This covers the same-cycle register file write that RD would miss.
  - Priority: EX > MEM > WB > register file. fwd_sel_A/B record the source used.
- hazard_stall = valid_D & valid_E & mem_to_reg_E & reg_write_E & ((A1_D == A3_E & A1_D != 15) | (A2_D == A3_E & A2_D != 15)).
  - Evaluated combinationally from the current _E registers; held low during reset.
  - Lasts exactly one cycle for a single load-use pair. The following cycle the load is in MEM and the MEM bypass supplies its result.
- valid_D = 0 loads a bubble, with no hazard and no bypass evaluation effect.
- Reset asserted mid-stall: reset wins on the same edge.

Optional Feature:
DECODE_BYPASS_EN
- Defined: bypass network behaves as specified above.
- Undefined:
  - SrcA_E and WriteData_E capture RDx_D directly; fwd_sel outputs are constant 0.
  - hazard_stall additionally asserts for any RAW match (source register != 15) against valid_E&reg_write_E, mem_reg_write or wb_reg_write destinations.
  - The stage inserts bubbles until the hazard clears.

Test Plan:
- Reset held 2 cycles with valid_D=1 and reg_write_D=1 applied -> all outputs 0 and valid_E=0 for both cycles. First load after reset release: RD1_D=0x11 -> SrcA_E=0x11.
- ADD R1 in E (ex_result=0x5) and MEM writing R1=0x7; next instruction A1_D=1 -> SrcA_E=0x5, fwd_sel_A=1.
- Only wb_reg_write, wb_A3=2, wb_result=0xAB, with RD2_D stale at 0x0; A2_D=2 -> WriteData_E=0xAB, fwd_sel_B=3.
- LDR R3 in E (mem_to_reg_E=1), then A1_D=3 -> hazard_stall=1 and bubble loaded. Next cycle mem_result=0x99 with mem_A3=3 -> SrcA_E=0x99.
- A1_D=15 with every bypass source targeting 15 -> SrcA_E=RD1_D (0x108), fwd_sel_A=0.
- stall=1 for 3 cycles with changing inputs -> outputs frozen. Then flush=1 together with stall=1 -> bubble, valid_E=0, reg_write_E=0.
